phy_rx_lane_sync: RTL and testbench
===================================

// Module: phy_rx_lane_sync
// PURPOSE
//  Receive end of the single-lane serial PHY link: takes the MSB-first serial bit stream from a lane
//  transmitter, finds byte alignment on COM symbols, and rebuilds 32-bit words.
//  Sits between the serial line and the receive-side word bus, in the bit-clock domain.
//  COM bytes are alignment/idle fillers; every other aligned byte is payload.
// PARAMETERS
//  COM        8'hBC  alignment/idle symbol value
//  SYNC_COMS  4      consecutive byte-aligned COMs needed to declare sync (>=1)
//  LOS_BYTES  64     max aligned bytes without a COM before sync is dropped (only with PHY_RX_LOS_EN)
// PORTS
//  clk         in   1   serial bit clock; one line bit per rising edge
//  reset       in   1   asynchronous, active-low reset
//  serial_in   in   1   serial line bit, MSB of each byte first
//  output_bus  out  32  last completed word; first received byte in [31:24]
//  valid_out   out  1   one-cycle pulse: output_bus carries a new word
//  active      out  1   high while in SYNCED
// BEHAVIOUR
//  Reset (reset==0, async): state=SEARCH; shift reg, bit_cnt, com_cnt, byte_idx, gap_cnt =0;
//   output_bus=0, valid_out=0, active=0. All outputs registered.
//  Shift: every edge sr <= {sr[6:0], serial_in}; "nsr" = that next value.
//  SEARCH: checks nsr==COM on every edge (bit-granular). On match: bit_cnt<=0 (next edge starts
//   a byte), com_cnt<=1; if SYNC_COMS==1 -> SYNCED, else -> ALIGN.
//  ALIGN: bit_cnt counts 0..7, wraps. At bit_cnt==7 (byte boundary): nsr==COM -> com_cnt+1, and
//   when com_cnt+1==SYNC_COMS -> SYNCED; nsr!=COM -> SEARCH, com_cnt<=0. Nothing between boundaries.
//  SYNCED: active=1. At each byte boundary:
//   - nsr==COM: idle; any partial word is discarded, byte_idx<=0; gap_cnt<=0.
//   - else: byte stored in slot byte_idx (0 -> [31:24] ... 3 -> [7:0]); byte_idx+1 (2-bit wrap).
//     On byte_idx==3: whole word -> output_bus, valid_out=1 the cycle after the edge sampling
//     the word's final bit (latency 1 clk from last bit). gap_cnt+1.
//  valid_out never high two consecutive cycles (min 32 clk between pulses); output_bus holds
//   its value between pulses and across loss of sync; cleared only by reset.
//  Leaving SYNCED (LOS): active<=0, byte_idx<=0 (partial discarded), com_cnt<=0, -> SEARCH.
//  Reset asserted mid-word: word lost, no valid_out pulse; restart from SEARCH on release.
//  Counter widths: bit_cnt 3b, byte_idx 2b, com_cnt $clog2(SYNC_COMS+1), gap_cnt $clog2(LOS_BYTES+1);
//   gap_cnt saturates, never wraps.
// CONFIGURATION
//  PHY_RX_LOS_EN defined: in SYNCED, boundary with gap_cnt+1==LOS_BYTES and nsr!=COM -> LOS
//   (that byte not stored). Requires transmitter to insert a COM at least every LOS_BYTES bytes.
//  PHY_RX_LOS_EN undefined: no gap_cnt logic; once SYNCED, stays SYNCED until reset.
// STRUCTURE
//  Shared package phy_pkg: COM default constant, state encoding (SEARCH/ALIGN/SYNCED, 2b),
//   bit/byte counter widths.
//  Sub-module phy_rx_word_asm: takes aligned byte + byte strobe + is_com + flush, owns byte_idx,
//   word register, output_bus/valid_out. Top keeps shift reg, bit_cnt, FSM, gap_cnt.
// TESTING
//  1. Reset low mid-stream -> all outputs 0 immediately (no clock needed); held 0 until release.
//  2. 3 junk bits then 4x 0xBC, then 0x12,0x34,0x56,0x78 -> active high after 4th COM boundary;
//     valid_out one pulse, output_bus=32'h12345678, 1 clk after bit 0 of 0x78.
//  3. Sync, then 0xAA,0xBB,COM,0x01,0x02,0x03,0x04 -> single pulse with 32'h01020304; AA/BB dropped.
//  4. 3x COM then 0x55 before sync -> back to SEARCH, active stays 0; next 4x COM -> active=1.
//  5. PHY_RX_LOS_EN, LOS_BYTES=64: sync then 64 data bytes no COM -> 15 words out, active drops at
//     64th boundary; without macro -> 16 words out, active stays 1.
//  6. Back-to-back words (no COM) -> valid_out pulses exactly every 32 clk, data in order.

Source files
------------

// File: rtl/phy_pkg.sv
// Shared definitions for the serial PHY receive lane: COM symbol, FSM encoding, counter widths.
package phy_pkg;

  localparam logic [7:0] COM_DEFAULT = 8'hBC;
  localparam int BIT_CNT_W  = 3;
  localparam int BYTE_IDX_W = 2;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    ALIGN  = 2'd1,
    SYNCED = 2'd2
  } rx_state_e;

endpackage

// File: rtl/phy_rx_lane_sync_if.sv
// Receive-lane signal bundle: serial line in, rebuilt word bus and status out.
interface phy_rx_lane_sync_if;

  logic        serial_in;
  logic [31:0] output_bus;
  logic        valid_out;
  logic        active;

  modport master (input serial_in, output output_bus, output valid_out, output active);
  modport slave  (output serial_in, input output_bus, input valid_out, input active);

endinterface

// File: rtl/phy_rx_word_asm.sv
// Packs aligned payload bytes into 32-bit words, first byte in [31:24]; COM or flush
// discards any partially built word.
module phy_rx_word_asm
  import phy_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  byte_in,
  input  logic        byte_stb,
  input  logic        is_com,
  input  logic        flush,
  output logic [31:0] output_bus,
  output logic        valid_out
);

  logic [BYTE_IDX_W-1:0] byte_idx_q, byte_idx_d;
  logic [23:0]           word_q, word_d;
  logic [31:0]           bus_q, bus_d;
  logic                  valid_q, valid_d;

  // Slots 0..2 are buffered; slot 3 completes the word straight into the output register.
  always_comb begin
    byte_idx_d = byte_idx_q;
    word_d     = word_q;
    bus_d      = bus_q;
    valid_d    = 1'b0;
    if (flush) begin
      byte_idx_d = '0;
    end else if (byte_stb) begin
      if (is_com) begin
        byte_idx_d = '0;
      end else begin
        case (byte_idx_q)
          2'd0:    word_d[23:16] = byte_in;
          2'd1:    word_d[15:8]  = byte_in;
          2'd2:    word_d[7:0]   = byte_in;
          default: begin
            bus_d   = {word_q, byte_in};
            valid_d = 1'b1;
          end
        endcase
        byte_idx_d = byte_idx_q + BYTE_IDX_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      byte_idx_q <= '0;
      word_q     <= '0;
      bus_q      <= '0;
      valid_q    <= 1'b0;
    end else begin
      byte_idx_q <= byte_idx_d;
      word_q     <= word_d;
      bus_q      <= bus_d;
      valid_q    <= valid_d;
    end
  end

  assign output_bus = bus_q;
  assign valid_out  = valid_q;

endmodule

// File: rtl/phy_rx_lane_sync.sv
// Serial PHY receive lane: bit-granular COM search, byte alignment, sync FSM and word rebuild.
// Optional loss-of-sync detection on missing COMs is enabled with `define PHY_RX_LOS_EN.
module phy_rx_lane_sync
  import phy_pkg::*;
#(
  parameter logic [7:0] COM       = COM_DEFAULT,
  parameter int         SYNC_COMS = 4
`ifdef PHY_RX_LOS_EN
  ,
  parameter int         LOS_BYTES = 64
`endif
) (
  input  logic               clk,
  input  logic               reset,
  phy_rx_lane_sync_if.master bus
);

  localparam int CW = $clog2(SYNC_COMS + 1);
  localparam logic [CW-1:0] SYNC_TARGET = CW'(SYNC_COMS);

  rx_state_e              state_q, state_d;
  logic [6:0]             sr_q, sr_d;
  logic [BIT_CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [CW-1:0]          com_cnt_q, com_cnt_d;
  logic                   active_q, active_d;
  logic [7:0]             nsr;
  logic                   is_com;
  logic                   boundary;
  logic                   byte_stb;
  logic                   flush;

`ifdef PHY_RX_LOS_EN
  localparam int GW = $clog2(LOS_BYTES + 1);
  localparam logic [GW-1:0] LOS_TARGET = GW'(LOS_BYTES);
  logic [GW-1:0] gap_cnt_q, gap_cnt_d, gap_inc;
  assign gap_inc = gap_cnt_q + GW'(1);
`endif

  // Only seven history bits are kept: the byte under test is always those plus the incoming bit.
  assign nsr      = {sr_q, bus.serial_in};
  assign is_com   = (nsr == COM);
  assign boundary = (bit_cnt_q == '1);

  always_comb begin
    state_d   = state_q;
    sr_d      = nsr[6:0];
    bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
    com_cnt_d = com_cnt_q;
    byte_stb  = 1'b0;
    flush     = 1'b0;
`ifdef PHY_RX_LOS_EN
    gap_cnt_d = '0;
`endif
    case (state_q)
      SEARCH: begin
        bit_cnt_d = '0;
        if (is_com) begin
          com_cnt_d = CW'(1);
          if (SYNC_COMS == 1) state_d = SYNCED;
          else                state_d = ALIGN;
        end
      end
      ALIGN: begin
        if (boundary) begin
          if (is_com) begin
            com_cnt_d = com_cnt_q + CW'(1);
            if (com_cnt_d == SYNC_TARGET) state_d = SYNCED;
          end else begin
            com_cnt_d = '0;
            state_d   = SEARCH;
          end
        end
      end
      SYNCED: begin
`ifdef PHY_RX_LOS_EN
        gap_cnt_d = gap_cnt_q;
        if (boundary) begin
          if (!is_com && gap_inc == LOS_TARGET) begin
            state_d   = SEARCH;
            flush     = 1'b1;
            com_cnt_d = '0;
            gap_cnt_d = '0;
          end else begin
            byte_stb = 1'b1;
            if (is_com)                      gap_cnt_d = '0;
            else if (gap_cnt_q != LOS_TARGET) gap_cnt_d = gap_inc;
          end
        end
`else
        byte_stb = boundary;
`endif
      end
      default: begin
        state_d   = SEARCH;
        com_cnt_d = '0;
        flush     = 1'b1;
      end
    endcase
    active_d = (state_d == SYNCED);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= SEARCH;
      sr_q      <= '0;
      bit_cnt_q <= '0;
      com_cnt_q <= '0;
      active_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      bit_cnt_q <= bit_cnt_d;
      com_cnt_q <= com_cnt_d;
      active_q  <= active_d;
    end
  end

`ifdef PHY_RX_LOS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) gap_cnt_q <= '0;
    else        gap_cnt_q <= gap_cnt_d;
  end
`endif

  assign bus.active = active_q;

  phy_rx_word_asm u_word_asm (
    .clk        (clk),
    .reset      (reset),
    .byte_in    (nsr),
    .byte_stb   (byte_stb),
    .is_com     (is_com),
    .flush      (flush),
    .output_bus (bus.output_bus),
    .valid_out  (bus.valid_out)
  );

endmodule

// File: tb/tb_phy_rx_lane_sync.sv
// Scoreboard bench for phy_rx_lane_sync: byte-level reference model predicts words and
// their completion edge; a negedge monitor pops and compares. Honours `define PHY_RX_LOS_EN.
module tb_phy_rx_lane_sync;

  localparam logic [7:0] COM  = 8'hBC;
  localparam int         SYNC = 4;
`ifdef PHY_RX_LOS_EN
  localparam int LOS       = 64;
  localparam int EXP_WORDS = 15;
  localparam logic EXP_ACTIVE_AFTER_LOS = 1'b0;
`else
  localparam int EXP_WORDS = 16;
  localparam logic EXP_ACTIVE_AFTER_LOS = 1'b1;
`endif

  typedef struct {
    logic [31:0] data;
    int          stamp;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  phy_rx_lane_sync_if bus_if ();

  phy_rx_lane_sync dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if.master)
  );

  int          checks     = 0;
  int          errors     = 0;
  int          edgeCnt    = 0;
  int          validCount = 0;
  logic [31:0] heldWord   = '0;
  exp_t        expQ[$];
  exp_t        popped;

  // Reference model state: sliding 8-bit window, lock mode, alignment anchor edge.
  int         win       = 0;
  int         mode      = 0;
  int         anchor    = 0;
  int         comsSeen  = 0;
  int         gap       = 0;
  logic [7:0] pending[$];

  always @(posedge clk) edgeCnt++;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h (edge %0d)", name, act, exp, edgeCnt);
    end
  endtask

  // Mode 0 hunts every bit, mode 1 counts aligned COMs, mode 2 is locked and collects payload.
  function automatic void modelStep(input logic b, input int t);
    exp_t e;
    win = ((win << 1) | int'(b)) & 255;
    case (mode)
      0: if (win == COM) begin
        anchor   = t;
        comsSeen = 1;
        mode     = (SYNC == 1) ? 2 : 1;
      end
      1: if ((t - anchor) % 8 == 0) begin
        if (win == COM) begin
          comsSeen++;
          if (comsSeen == SYNC) mode = 2;
        end else begin
          mode     = 0;
          comsSeen = 0;
        end
      end
      default: if ((t - anchor) % 8 == 0) begin
        if (win == COM) begin
          pending.delete();
          gap = 0;
        end
`ifdef PHY_RX_LOS_EN
        else if (gap + 1 == LOS) begin
          mode     = 0;
          comsSeen = 0;
          gap      = 0;
          pending.delete();
        end
`endif
        else begin
          pending.push_back(win[7:0]);
          gap++;
          if (pending.size() == 4) begin
            e.data  = {pending[0], pending[1], pending[2], pending[3]};
            e.stamp = t;
            expQ.push_back(e);
            pending.delete();
          end
        end
      end
    endcase
  endfunction

  task automatic applyStimulus(input logic b);
    @(negedge clk);
    bus_if.serial_in = b;
    modelStep(b, edgeCnt + 1);
    @(posedge clk);
    #1;
    checkOutput("active", {31'd0, bus_if.active}, {31'd0, mode == 2});
  endtask

  task automatic sendByte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) applyStimulus(v[i]);
  endtask

  task automatic sendBits(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'($urandom_range(0, 1)));
  endtask

  task automatic sendComs(input int n);
    for (int i = 0; i < n; i++) sendByte(COM);
  endtask

  task automatic sendData(input int n, input bit allowCom);
    logic [7:0] v;
    for (int i = 0; i < n; i++) begin
      v = 8'($urandom_range(0, 255));
      if (allowCom && $urandom_range(0, 5) == 0) v = COM;
      while (!allowCom && v == COM) v = 8'($urandom_range(0, 255));
      sendByte(v);
    end
  endtask

  // Called just after an active edge; a pulse from that edge is killed by the reset.
  task automatic applyReset();
    reset    = 1'b0;
    heldWord = '0;
    while (expQ.size() > 0 && expQ[expQ.size() - 1].stamp >= edgeCnt) expQ.delete(expQ.size() - 1);
    win      = 0;
    mode     = 0;
    comsSeen = 0;
    gap      = 0;
    pending.delete();
    #1;
    checkOutput("reset bus", bus_if.output_bus, 32'h0);
    checkOutput("reset valid", {31'd0, bus_if.valid_out}, 32'h0);
    checkOutput("reset active", {31'd0, bus_if.active}, 32'h0);
    repeat (3) @(posedge clk);
    #3;
    reset = 1'b1;
  endtask

  always @(negedge clk) begin
    if (bus_if.valid_out) begin
      validCount++;
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected word: got %h expected none (edge %0d)", bus_if.output_bus, edgeCnt);
      end else begin
        popped = expQ.pop_front();
        checkOutput("word data", bus_if.output_bus, popped.data);
        checkOutput("word edge", edgeCnt, popped.stamp);
        heldWord = popped.data;
      end
    end else begin
      if (expQ.size() > 0 && expQ[0].stamp <= edgeCnt) begin
        popped = expQ.pop_front();
        checks++;
        errors++;
        $display("[TB] FAIL missed word: got no pulse expected %h at edge %0d", popped.data, popped.stamp);
      end
      checkOutput("bus hold", bus_if.output_bus, heldWord);
    end
  end

  initial begin
    #1000000;
    errors++;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int vc;
    bus_if.serial_in = 1'b0;
    #1;
    applyReset();

    $display("[TB] junk bits, sync, 12345678");
    sendBits(3);
    sendComs(4);
    sendByte(8'h12); sendByte(8'h34); sendByte(8'h56); sendByte(8'h78);
    checkOutput("first word", bus_if.output_bus, 32'h12345678);
    checkOutput("first valid", {31'd0, bus_if.valid_out}, 32'h1);

    $display("[TB] partial word dropped by COM");
    sendByte(8'hAA); sendByte(8'hBB); sendByte(COM);
    sendByte(8'h01); sendByte(8'h02); sendByte(8'h03); sendByte(8'h04);
    checkOutput("second word", bus_if.output_bus, 32'h01020304);

    $display("[TB] reset mid-word");
    sendByte(8'h11);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0);
    applyReset();

    $display("[TB] broken COM run");
    sendComs(3);
    sendByte(8'h55);
    checkOutput("no sync", {31'd0, bus_if.active}, 32'h0);
    sendComs(4);
    checkOutput("resync", {31'd0, bus_if.active}, 32'h1);

    $display("[TB] back-to-back words");
    sendData(12, 1'b0);

    $display("[TB] long run without COM");
    @(posedge clk);
    #1;
    applyReset();
    sendComs(4);
    vc = validCount;
    sendData(64, 1'b0);
    checkOutput("long run active", {31'd0, bus_if.active}, {31'd0, EXP_ACTIVE_AFTER_LOS});
    @(negedge clk);
    #1;
    checkOutput("long run words", 32'(validCount - vc), 32'(EXP_WORDS));

    $display("[TB] random rounds");
    for (int r = 0; r < 8; r++) begin
      sendBits($urandom_range(0, 12));
      sendComs($urandom_range(3, 5));
      sendData($urandom_range(4, 24), 1'b1);
    end

    repeat (3) @(negedge clk);
    #1;
    checkOutput("drained", 32'(expQ.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
